// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath; optional BEQ support under `CONTROL_BRANCH_EN.
// Latency: LW 5, SW/R-type/ADDI 4, BEQ 3, unsupported 3 cycles; outputs decode from registered state.
// No backpressure: advances every cycle, synchronous active-high reset returns to FETCH.
module multicycle_control_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           OP,
    input  logic [5:0]           Funct,
    input  logic                 Zero,
    output logic                 PCWrite,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUControl,
    output logic                 PCSrc,
    output logic [3:0]           state_o,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        ADDIEXEC = 4'd8,
        ADDIWB   = 4'd9,
        BRANCH   = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    state_t     state;
    state_t     next_state;
    logic [3:0] rtype_alu;
    logic       rtype_ok;
    logic [3:0] rtype_alu_q;
    logic       retire;

    // Funct is only trusted in DECODE, so the R-type ALU op is captured there for EXECUTE.
    always_comb begin
        rtype_alu = ALU_ADD;
        rtype_ok  = 1'b1;
        case (Funct)
            6'h20:   rtype_alu = ALU_ADD;
            6'h22:   rtype_alu = ALU_SUB;
            6'h24:   rtype_alu = ALU_AND;
            6'h25:   rtype_alu = ALU_OR;
            6'h27:   rtype_alu = ALU_NOR;
            6'h00:   rtype_alu = ALU_SLL;
            6'h02:   rtype_alu = ALU_SRL;
            default: rtype_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH: next_state = DECODE;
            DECODE: begin
                case (OP)
                    OP_RTYPE: next_state = rtype_ok ? EXECUTE : ILLEGAL;
                    OP_LW,
                    OP_SW:    next_state = MEMADR;
                    OP_ADDI:  next_state = ADDIEXEC;
`ifdef CONTROL_BRANCH_EN
                    OP_BEQ:   next_state = BRANCH;
`endif
                    default:  next_state = ILLEGAL;
                endcase
            end
            MEMADR:   next_state = (OP == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTE:  next_state = ALUWB;
            ADDIEXEC: next_state = ADDIWB;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        PCSrc      = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    IRWrite    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = ALU_ADD;
                    PCWrite    = 1'b1;
                end
                DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = ALU_ADD;
                end
                MEMADR, ADDIEXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_ADD;
                end
                MEMREAD: IorD = 1'b1;
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = rtype_alu_q;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ADDIWB: RegWrite = 1'b1;
                // Unreachable without branch support, which is what leaves Zero without effect.
                BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    PCSrc      = 1'b1;
                    PCWrite    = Zero;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rtype_alu_q <= ALU_ADD;
        end else if (state == DECODE) begin
            rtype_alu_q <= rtype_alu;
        end
    end

    always_comb begin
        case (state)
            MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH: retire = 1'b1;
            default:                               retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_o   <= 1'b0;
            instr_cnt_o <= '0;
        end else begin
            if (next_state == ILLEGAL) begin
                illegal_o <= 1'b1;
            end
            if (retire) begin
                instr_cnt_o <= instr_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; honours `CONTROL_BRANCH_EN when defined.
// A second instance with CNT_WIDTH=2 shares the stimulus to exercise counter wrap.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       pc_src;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OP;
    logic [5:0]  Funct;
    logic        Zero;

    logic        PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUControl, state_o;
    logic        illegal_o;
    logic [15:0] instr_cnt_o;

    logic        PCWrite2, IorD2, MemWrite2, IRWrite2, RegDst2, MemtoReg2, RegWrite2, ALUSrcA2, PCSrc2;
    logic [1:0]  ALUSrcB2;
    logic [3:0]  ALUControl2, state2;
    logic        illegal2;
    logic [1:0]  instr_cnt2;

    ctrl_t ctrl, ctrl2;
    assign ctrl  = {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, ALUControl, PCSrc};
    assign ctrl2 = {PCWrite2, IorD2, MemWrite2, IRWrite2, RegDst2, MemtoReg2, RegWrite2, ALUSrcA2,
                    ALUSrcB2, ALUControl2, PCSrc2};

    int tests  = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .state_o(state_o), .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
    );

    multicycle_control_unit #(.CNT_WIDTH(2)) dut_w2 (
        .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite2), .IorD(IorD2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
        .RegDst(RegDst2), .MemtoReg(MemtoReg2), .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2),
        .ALUSrcB(ALUSrcB2), .ALUControl(ALUControl2), .PCSrc(PCSrc2),
        .state_o(state2), .illegal_o(illegal2), .instr_cnt_o(instr_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected control word for a state, written straight from the per-state output table.
    function automatic ctrl_t exp_ctrl(input logic [3:0] s, input logic [3:0] alu, input logic z);
        ctrl_t c;
        c = '0;
        case (s)
            4'd0:  begin c.ir_write = 1; c.alu_src_b = 2'b01; c.alu_control = 4'b0100; c.pc_write = 1; end
            4'd1:  begin c.alu_src_b = 2'b11; c.alu_control = 4'b0100; end
            4'd2, 4'd8: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 4'b0100; end
            4'd3:  c.iord = 1;
            4'd4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            4'd5:  begin c.iord = 1; c.mem_write = 1; end
            4'd6:  begin c.alu_src_a = 1; c.alu_control = alu; end
            4'd7:  begin c.reg_dst = 1; c.reg_write = 1; end
            4'd9:  c.reg_write = 1;
            4'd10: begin c.alu_src_a = 1; c.alu_control = 4'b0101; c.pc_src = 1; c.pc_write = z; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks n states (nibble 0 of seq first), checking state and control word of both instances.
    task automatic run(input logic [5:0] op, input logic [5:0] funct, input logic z,
                       input int n, input logic [31:0] seq, input logic [3:0] alu);
        logic [3:0] s;
        OP = op; Funct = funct; Zero = z;
        for (int i = 0; i < n; i++) begin
            s = seq[4*i +: 4];
            check("state", 32'(state_o), 32'(s));
            check("ctrl", 32'(ctrl), 32'(exp_ctrl(s, alu, z)));
            check("state_w2", 32'(state2), 32'(s));
            check("ctrl_w2", 32'(ctrl2), 32'(exp_ctrl(s, alu, z)));
            step();
        end
    endtask

    initial begin
        reset = 1'b1; OP = 6'h00; Funct = 6'h00; Zero = 1'b0;
        step();
        step();
        check("reset_ctrl", 32'(ctrl), 32'h0);
        check("reset_state", 32'(state_o), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_ctrl", 32'(ctrl), 32'(exp_ctrl(4'd0, 4'd0, 1'b0)));
        check("rel_illegal", 32'(illegal_o), 32'd0);
        check("rel_cnt", 32'(instr_cnt_o), 32'd0);

        run(6'h00, 6'h22, 1'b0, 4, 32'h7610, 4'b0101);
        exp_cnt = 1; check("cnt_sub", 32'(instr_cnt_o), 32'(exp_cnt));

        run(6'h23, 6'h00, 1'b0, 5, 32'h43210, 4'b0000);
        run(6'h2B, 6'h00, 1'b0, 4, 32'h5210, 4'b0000);
        exp_cnt = 3; check("cnt_lwsw", 32'(instr_cnt_o), 32'(exp_cnt));

        run(6'h08, 6'h00, 1'b0, 4, 32'h9810, 4'b0000);
        check("illegal_pre", 32'(illegal_o), 32'd0);
        run(6'h3F, 6'h00, 1'b0, 3, 32'hB10, 4'b0000);
        check("illegal_set", 32'(illegal_o), 32'd1);
        run(6'h08, 6'h00, 1'b0, 4, 32'h9810, 4'b0000);
        check("illegal_hold", 32'(illegal_o), 32'd1);
        exp_cnt = 5; check("cnt_addi", 32'(instr_cnt_o), 32'(exp_cnt));

        run(6'h00, 6'h25, 1'b0, 4, 32'h7610, 4'b0001);
        run(6'h00, 6'h00, 1'b0, 4, 32'h7610, 4'b0110);
        run(6'h00, 6'h02, 1'b0, 4, 32'h7610, 4'b0111);
        run(6'h00, 6'h24, 1'b0, 4, 32'h7610, 4'b0000);
        run(6'h00, 6'h3F, 1'b0, 3, 32'hB10, 4'b0000);
        exp_cnt = 9; check("cnt_rtype", 32'(instr_cnt_o), 32'(exp_cnt));

`ifdef CONTROL_BRANCH_EN
        run(6'h04, 6'h00, 1'b1, 3, 32'hA10, 4'b0000);
        run(6'h04, 6'h00, 1'b0, 3, 32'hA10, 4'b0000);
        exp_cnt = 11;
`else
        run(6'h04, 6'h00, 1'b1, 3, 32'hB10, 4'b0000);
        run(6'h04, 6'h00, 1'b0, 3, 32'hB10, 4'b0000);
`endif
        check("cnt_beq", 32'(instr_cnt_o), 32'(exp_cnt));

        // Reset landing in MEMREAD.
        run(6'h23, 6'h00, 1'b0, 3, 32'h210, 4'b0000);
        check("memread_state", 32'(state_o), 32'd3);
        check("memread_ctrl", 32'(ctrl), 32'(exp_ctrl(4'd3, 4'd0, 1'b0)));
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'(ctrl), 32'h0);
        step();
        check("rst_mid_state", 32'(state_o), 32'd0);
        check("rst_mid_wen", 32'({MemWrite, RegWrite}), 32'd0);
        check("rst_mid_illegal", 32'(illegal_o), 32'd0);
        check("rst_mid_cnt", 32'(instr_cnt_o), 32'd0);
        check("rst_mid_cnt_w2", 32'(instr_cnt2), 32'd0);
        reset = 1'b0;
        #1;

        for (int k = 0; k < 3; k++) run(6'h08, 6'h00, 1'b0, 4, 32'h9810, 4'b0000);
        check("w2_cnt3", 32'(instr_cnt2), 32'd3);
        run(6'h08, 6'h00, 1'b0, 4, 32'h9810, 4'b0000);
        check("w2_wrap", 32'(instr_cnt2), 32'd0);
        check("cnt16_4", 32'(instr_cnt_o), 32'd4);
        check("w2_illegal", 32'(illegal2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
